n_bit_factorial_inverse: RTL
============================

# n_bit_factorial_inverse

Sequential inverse of the combinational N-bit factorial block. It takes a 10*N-bit value and searches iteratively for n such that n! equals that value. It reports whether an exact match exists and the matching n. It sits downstream of `N_bit_factorial`: it decodes a factorial result back to its operand, for self-check and round-trip paths.

## Interface
Parameters:
- N, 4, width of the recovered number; the search bound is 2^N-1.

Ports (reset is synchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  request pulse; sampled only in IDLE.
- Factorial  input  10*N  value to invert; sampled on the accepted Start edge.
- Busy  output  1  high while a search is in progress.
- Done  output  1  one-cycle pulse when the result is valid.
- Found  output  1  1 = exact match, 0 = value is not a factorial.
- Number  output  N  recovered n; meaning depends on Found and the configuration.

## Operation
- Internal state:
  - target register, 10*N bits.
  - acc register, 11*N bits, holds k!.
  - k counter, N bits.
- States: IDLE, SEARCH.
- IDLE:
  - Start=1 latches Factorial into target, sets acc=1, k=0, Busy=1, and moves to SEARCH.
  - Start=0 holds state.
- SEARCH, each cycle, evaluated in priority order on the registered acc and k:
  1. acc == target: Found=1, Number=k, Done=1, go to IDLE.
  2. acc > target: Found=0, Number per Configuration, Done=1, go to IDLE.
  3. k == 2^N-1: same as case 2.
  4. Otherwise: k=k+1, acc=acc*(k+1), stay in SEARCH.
- Arithmetic width:
  - acc ≤ target < 2^(10N) before each multiply.
  - The product fits in 11*N bits, so no overflow handling is needed.
- Boundary cases:
  - 0! and 1! both equal 1. Target=1 returns the smallest n: Number=0, Found=1.
  - Target=0 is never a match: Found=0 on the first SEARCH cycle.
- Start while Busy is ignored. Factorial changes during SEARCH have no effect.
- Found and Number hold their last result until the next accepted Start. On an accepted Start they are not cleared; they simply update on completion.
- rst, at any time including mid-search:
  - Next state is IDLE.
  - Busy=0, Done=0, Found=0, Number=0, k=0, acc=1, target=0.
  - rst has priority over Start.

## Timing
- Reset values: Busy=0, Done=0, Found=0, Number=0.
- Let edge E0 be the one that samples Start=1 in IDLE.
  - Busy rises after E0.
  - The SEARCH comparison for k=j happens at edge E(j+1).
- Exact match n: Done, Found, and Number update after E(n+1). Latency is n+1 edges.
- Non-match: Done updates after E(m+1), where m is the first k with k! > target, or m=2^N-1.
- Done is high for exactly one cycle. Busy falls on the same edge that Done rises.
- A new Start is accepted on the edge after Done is high. Back-to-back throughput is one search per (latency+1) cycles.
- Maximum latency is 2^N edges.

## Configuration
- FACT_INV_FLOOR_EN, when defined:
  - On a non-match, Number is the largest k whose k! < target, i.e. the k value before the final increment.
  - If the stop is due to k == 2^N-1, Number=2^N-1.
  - For target=0, Number=0.
- Not defined: on a non-match, Number=0.
- Found and Done behaviour is identical in both builds.

## Test plan
- After rst, Factorial=24 with a Start pulse -> Done after 5 edges, Found=1, Number=4, Busy low in the same cycle as Done.
- Factorial=1 -> Done after 1 edge, Found=1, Number=0. Factorial=0 -> Done after 1 edge, Found=0, Number=0.
- Factorial=25 -> Done after 6 edges, Found=0, Number=0. With FACT_INV_FLOOR_EN, Number=4.
- Factorial=3628800 -> Done after 11 edges, Found=1, Number=10. Extra Start pulses during Busy are ignored: exactly one Done pulse.
- Factorial=2^40-1 (N=4) -> Done after 16 edges, Found=0, Number=0. With FACT_INV_FLOOR_EN, Number=14.
- Factorial=87178291200 (14!), rst asserted at edge E7 -> Busy=0, Done=0, Number=0 after that edge and no Done pulse follows. Restart -> Found=1, Number=14 after 15 edges.

Source files
------------

// File: rtl/n_bit_factorial_inverse.sv
// Iterative inverse of n!: walks k!, k = 0..2^N-1, against a latched target and reports the exact match.
// Optional FACT_INV_FLOOR_EN: on a non-match, Number reports the largest k with k! below the target.
//
// state  | meaning
// IDLE   | waiting for Start; last result held on Found/Number
// SEARCH | comparing acc = k! with target, one k per clock
module n_bit_factorial_inverse #(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic [10*N-1:0]   Factorial,
  output logic              Busy,
  output logic              Done,
  output logic              Found,
  output logic [N-1:0]      Number
);

  localparam int TW = 10 * N;
  localparam int AW = 11 * N;
  localparam logic [N-1:0] KMAX = '1;
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t          state;
  logic [TW-1:0]   target;
  logic [AW-1:0]   acc;
  logic [N-1:0]    k;

  logic [AW-1:0]   target_ext;
  logic [AW-1:0]   acc_next;
  logic            hit;
  logic            over;
  logic            stop_miss;
  logic [N-1:0]    miss_number;

  // acc <= target < 2^(10N) before each multiply, so the product never exceeds 11N bits
  assign target_ext = {{N{1'b0}}, target};
  assign acc_next   = acc * (AW'(k) + AW'(1));
  assign hit        = (acc == target_ext);
  assign over       = (acc > target_ext);
  assign stop_miss  = over || (k == KMAX);

`ifdef FACT_INV_FLOOR_EN
  always_comb begin
    miss_number = k;
    if (over) begin
      if (k == '0) miss_number = '0;
      else         miss_number = k - ONE;
    end
  end
`else
  assign miss_number = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Found  <= 1'b0;
      Number <= '0;
      k      <= '0;
      acc    <= AW'(1);
      target <= '0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            target <= Factorial;
            acc    <= AW'(1);
            k      <= '0;
            Busy   <= 1'b1;
            state  <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            Found  <= 1'b1;
            Number <= k;
            Done   <= 1'b1;
            Busy   <= 1'b0;
            state  <= IDLE;
          end else if (stop_miss) begin
            Found  <= 1'b0;
            Number <= miss_number;
            Done   <= 1'b1;
            Busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            k   <= k + ONE;
            acc <= acc_next;
          end
        end
      endcase
    end
  end

endmodule
